// File: rtl/dice_tid_dispatcher.sv
// dice_tid_dispatcher: issues the set TIDs of a snapshotted mask in ascending order, one per cycle, then waits a drain latency and pulses done
// Ports: clk/rst (async, active-high), clr (sync abort), start + tid_mask + drain_latency (launch),
//        stall (no issue while high), disp_tid/disp_valid (issue stream), busy, done (one-cycle pulse), issued_count
module dice_tid_dispatcher #(
    parameter int NUM_TID             = 512,
    parameter int MAX_CGRA_PIPE_STAGE = 32,
    parameter int MAX_IO_PIPE_STAGE   = 8,
    parameter int TID_W               = $clog2(NUM_TID + 1),
    parameter int DRAIN_W             = $clog2(MAX_CGRA_PIPE_STAGE + 2 * MAX_IO_PIPE_STAGE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               start,
    input  logic [NUM_TID-1:0] tid_mask,
    input  logic [DRAIN_W-1:0] drain_latency,
    input  logic               stall,
    output logic [TID_W-1:0]   disp_tid,
    output logic               disp_valid,
    output logic               busy,
    output logic               done,
    output logic [TID_W-1:0]   issued_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    localparam logic [NUM_TID-1:0] ONE = NUM_TID'(1);
    state_t             state_q, state_d;
    logic [NUM_TID-1:0] pending_q, pending_d, pending_rest;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [TID_W-1:0]   disp_tid_q, disp_tid_d, issued_count_q, issued_count_d, pick;
    logic               disp_valid_q, disp_valid_d, busy_q, busy_d, done_q, done_d;
    // lowest set bit of pending wins: scanning downward, the last hit is the smallest index
    always_comb begin
        pick = '0;
        for (int i = NUM_TID - 1; i >= 0; i--)
            if (pending_q[i]) pick = TID_W'(i);
    end
    // pending with its lowest set bit removed
    assign pending_rest = pending_q & (pending_q - ONE);
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        drain_cnt_d    = drain_cnt_q;
        disp_tid_d     = disp_tid_q;
        disp_valid_d   = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        issued_count_d = issued_count_q;
        if (clr) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pending_d      = tid_mask;
                    drain_cnt_d    = drain_latency;
                    issued_count_d = '0;
                    busy_d         = 1'b1;
                    // an empty mask skips the walk and starts draining right away
                    state_d        = |tid_mask ? SCAN : DRAIN;
                end
                SCAN: if (~|pending_q) begin
                    state_d = DRAIN;
                end else if (!stall) begin
                    disp_tid_d     = pick;
                    disp_valid_d   = 1'b1;
                    pending_d      = pending_rest;
                    issued_count_d = issued_count_q + TID_W'(1);
                    state_d        = |pending_rest ? SCAN : DRAIN;
                end
                DRAIN: if (drain_cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            drain_cnt_q    <= '0;
            disp_tid_q     <= '0;
            disp_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            drain_cnt_q    <= drain_cnt_d;
            disp_tid_q     <= disp_tid_d;
            disp_valid_q   <= disp_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            issued_count_q <= issued_count_d;
        end
    end
    assign disp_tid     = disp_tid_q;
    assign disp_valid   = disp_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = issued_count_q;
endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// tb_dice_tid_dispatcher: random and directed runs of dice_tid_dispatcher against a queue-based reference model
module tb_dice_tid_dispatcher;
    localparam int N  = 512;
    localparam int TW = 10;
    localparam int DW = 6;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [N-1:0]  tid_mask = '0;
    logic [DW-1:0] drain_latency = '0;
    logic [TW-1:0] disp_tid, issued_count;
    logic          disp_valid, busy, done;
    int total = 0, bad = 0, cyc = 0, s0 = 0;
    bit m_active = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int q[$];
    int m_tid = 0, m_cnt = 0, m_drain = 0, done_at = -1;
    int log_tids[$], log_cyc[$];
    int done_cyc = -1, done_n = 0, busy_n = 0;
    dice_tid_dispatcher dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .tid_mask(tid_mask),
        .drain_latency(drain_latency), .stall(stall), .disp_tid(disp_tid),
        .disp_valid(disp_valid), .busy(busy), .done(done), .issued_count(issued_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    function automatic logic [N-1:0] rand_mask();
        logic [N-1:0] m;
        for (int w = 0; w < N / 32; w++) m[w*32 +: 32] = $urandom;
        return m;
    endfunction
    // reference model: a queue of TIDs still to issue plus the absolute cycle at which done is due
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 0; m_valid = 0; m_busy = 0; m_done = 0; m_tid = 0; m_cnt = 0;
            q.delete();
        end else begin
            cyc++;
            m_valid = 0;
            m_done  = 0;
            if (clr) begin
                m_active = 0; m_busy = 0;
                q.delete();
            end else if (!m_active) begin
                if (start) begin
                    q.delete();
                    for (int i = 0; i < N; i++) if (tid_mask[i]) q.push_back(i);
                    m_cnt = 0; m_busy = 1; m_active = 1;
                    m_drain = int'(drain_latency);
                    done_at = (q.size() == 0) ? cyc + 1 + m_drain : -1;
                end
            end else if (q.size() > 0) begin
                if (!stall) begin
                    m_tid = q.pop_front();
                    m_valid = 1;
                    m_cnt++;
                    if (q.size() == 0) done_at = cyc + 1 + m_drain;
                end
            end else if (cyc == done_at) begin
                m_done = 1; m_busy = 0; m_active = 0;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("disp_valid", int'(disp_valid), int'(m_valid));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("issued_count", int'(issued_count), m_cnt);
            chk("disp_tid", int'(disp_tid), m_tid);
            if (disp_valid) begin
                log_tids.push_back(int'(disp_tid));
                log_cyc.push_back(cyc - s0);
            end
            if (done) begin
                done_cyc = cyc - s0;
                done_n++;
            end
            if (busy) busy_n++;
        end
    end
    task automatic launch(input logic [N-1:0] m, input int d, input bit now);
        if (!now) @(negedge clk);
        s0 = cyc;
        start = 1; tid_mask = m; drain_latency = DW'(d);
        log_tids.delete(); log_cyc.delete();
        done_n = 0; busy_n = 0; done_cyc = -1;
        @(negedge clk);
        start = 0; tid_mask = rand_mask();
    endtask
    task automatic run(input int budget, input int st_lo, input int st_hi, input int re_at, input int clr_at, input bit rnd);
        int k;
        int rel;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!m_active && !m_done) break;
            rel = cyc - s0;
            stall = rnd ? ($urandom_range(0, 3) == 0) : (rel >= st_lo && rel <= st_hi);
            start = (rel == re_at) || (rnd && !m_done && $urandom_range(0, 7) == 0);
            clr = (rel == clr_at) || (rnd && $urandom_range(0, 1999) == 0);
            tid_mask = rand_mask();
        end
        stall = 0; start = 0; clr = 0;
        chk("run_finished_in_budget", int'(k < budget), 1);
    endtask
    task automatic check_s1();
        chk("s1_issues", log_tids.size(), 3);
        if (log_tids.size() == 3) begin
            chk("s1_tid0", log_tids[0], 0);
            chk("s1_tid1", log_tids[1], 5);
            chk("s1_tid2", log_tids[2], 511);
            chk("s1_first_cycle", log_cyc[0], 2);
            chk("s1_last_cycle", log_cyc[2], 4);
        end
        chk("s1_done_cycle", done_cyc, 8);
        chk("s1_done_pulses", done_n, 1);
        chk("s1_issued_count", int'(issued_count), 3);
    endtask
    initial begin
        logic [N-1:0] m1, m;
        int old_s0;
        bit ok;
        m1 = '0; m1[0] = 1; m1[5] = 1; m1[511] = 1;
        #2 rst = 1;
        #1;
        chk("rst_disp_tid", int'(disp_tid), 0);
        chk("rst_disp_valid", int'(disp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_issued_count", int'(issued_count), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        launch(m1, 3, 0);
        run(100, -1, -1, -1, -1, 0);
        check_s1();
        launch('1, 0, 0);
        run(800, 10, 14, -1, -1, 0);
        ok = (log_tids.size() == 512);
        for (int i = 0; i < log_tids.size(); i++) if (log_tids[i] != i) ok = 0;
        chk("s2_ascending_all", int'(ok), 1);
        if (log_cyc.size() > 9) begin
            chk("s2_last_before_stall", log_cyc[8], 10);
            chk("s2_first_after_stall", log_cyc[9], 16);
        end
        chk("s2_done_cycle", done_cyc, 519);
        chk("s2_issued_count", int'(issued_count), 512);
        launch('0, 5, 0);
        run(50, -1, -1, -1, -1, 0);
        chk("s3_issues", log_tids.size(), 0);
        chk("s3_done_cycle", done_cyc, 7);
        chk("s3_busy_cycles", busy_n, 6);
        m = '0; m[7] = 1; m[8] = 1; m[100] = 1; m[200] = 1;
        launch(m, 2, 0);
        run(60, -1, -1, 3, -1, 0);
        chk("s4_issues", log_tids.size(), 4);
        chk("s4_done_pulses", done_n, 1);
        chk("s4_issued_count", int'(issued_count), 4);
        launch(N'(62), 2, 0);
        run(60, -1, -1, -1, 4, 0);
        chk("s5_issues", log_tids.size(), 3);
        if (log_tids.size() == 3) chk("s5_tids_123", int'(log_tids[0] == 1 && log_tids[1] == 2 && log_tids[2] == 3), 1);
        chk("s5_done_pulses", done_n, 0);
        chk("s5_issued_count", int'(issued_count), 3);
        old_s0 = s0;
        m = '0; m[9] = 1;
        launch(m, 1, 1);
        chk("s5_restart_cycle", s0 - old_s0, 5);
        run(60, -1, -1, -1, -1, 0);
        chk("s5b_issues", log_tids.size(), 1);
        if (log_tids.size() == 1) chk("s5b_issue_cycle", log_cyc[0], 2);
        chk("s5b_done_cycle", done_cyc, 4);
        launch(m1, 20, 0);
        repeat (8) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("s6_disp_tid", int'(disp_tid), 0);
        chk("s6_disp_valid", int'(disp_valid), 0);
        chk("s6_busy", int'(busy), 0);
        chk("s6_done", int'(done), 0);
        chk("s6_issued_count", int'(issued_count), 0);
        repeat (3) @(negedge clk);
        rst = 0;
        chk("s6_no_done", done_n, 0);
        launch(m1, 3, 0);
        run(100, -1, -1, -1, -1, 0);
        check_s1();
        for (int r = 0; r < 20; r++) begin
            m = rand_mask();
            for (int j = 0; j < r % 4; j++) m &= rand_mask();
            if (r % 5 == 4) m = '0;
            launch(m, int'($urandom_range(0, 12)), 0);
            run(2000, -1, -1, -1, -1, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
